// File: rtl/l6_array_sum.sv
// Memory-master sequencer for the lab-6 data memory: reads a count word, sums that
// many following words, and writes the 16-bit result back to RESULT_ADDR.
module l6_array_sum #(
   parameter int DW = 16,
   parameter int AW = 8,
   parameter logic [AW-1:0] BASE_ADDR   = 8'd48,
   parameter logic [AW-1:0] RESULT_ADDR = 8'd60
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_dout,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] sum,
   output logic          ovf,
   output logic          err
);

   typedef enum logic [2:0] {IDLE, LDCNT, ACCUM, WRITE, DONE} state_t;

   state_t        state, state_nxt;
   logic [7:0]    count_q;
   logic [7:0]    idx_q;
   logic [DW-1:0] sum_q;
   logic          ovf_q;
   logic          err_q;
   logic [DW:0]   add_res;
   logic          count_bad;

   assign add_res   = {1'b0, sum_q} + {1'b0, mem_dout};
   assign count_bad = |mem_dout[DW-1:8];

   assign mem_din = sum_q;
   assign sum     = sum_q;
   assign ovf     = ovf_q;
   assign err     = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Address and write strobe are purely state-decoded; the memory read is combinational.
   always_comb begin
      state_nxt = state;
      mem_addr  = '0;
      mem_wr    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = LDCNT;
         end
         LDCNT: begin
            mem_addr = BASE_ADDR;
            if (count_bad)                 state_nxt = DONE;
            else if (mem_dout[7:0] == 8'd0) state_nxt = WRITE;
            else                           state_nxt = ACCUM;
         end
         ACCUM: begin
            mem_addr = BASE_ADDR + AW'(1) + AW'(idx_q);
            if (idx_q == count_q - 8'd1) state_nxt = WRITE;
         end
         WRITE: begin
            mem_addr  = RESULT_ADDR;
            mem_wr    = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         idx_q   <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  count_q <= '0;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  ovf_q   <= 1'b0;
                  err_q   <= 1'b0;
               end
            end
            LDCNT: begin
               count_q <= mem_dout[7:0];
               if (count_bad) err_q <= 1'b1;
            end
            ACCUM: begin
               sum_q <= add_res[DW-1:0];
               ovf_q <= ovf_q | add_res[DW];
               idx_q <= idx_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/l6_array_sum.md
# l6_array_sum

Memory-master sequencer that sits directly upstream of the lab-6 data memory and drives its address, DataIn and MemWr inputs while consuming its combinational DataOut. On a start pulse it reads an element count from BASE_ADDR, accumulates the count words stored at BASE_ADDR+1 onward, and writes the 16-bit sum back to RESULT_ADDR. It then reports done, the sum, and overflow/error status to the controlling testbench or datapath.

## Interface
- BASE_ADDR, 8'd48: address of the count word; elements follow at BASE_ADDR+1 onward.
- RESULT_ADDR, 8'd60: address where the final sum is written.
- DW, 16: data width; must match the memory word.
- AW, 8: address width; must match the memory address.
- clk  input  1  rising-edge clock, shared with the memory.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- mem_addr  output  AW  drives the memory address.
- mem_din  output  DW  drives the memory DataIn.
- mem_wr  output  1  drives the memory MemWr.
- mem_dout  input  DW  memory DataOut; combinational read of mem_addr.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in DONE.
- sum  output  DW  accumulator value; holds the final result after done.
- ovf  output  1  sticky carry-out of any accumulate add during the current run.
- err  output  1  count word out of range (count[15:8] != 0).

## Operation
- States: IDLE, LDCNT, ACCUM, WRITE, DONE.
- IDLE
  - mem_addr=0, mem_wr=0; sum, ovf and err hold their last values.
  - start=1 moves to LDCNT and clears sum, ovf, err and idx.
- LDCNT
  - mem_addr=BASE_ADDR; count register <= mem_dout at the clock edge.
  - count[15:8] != 0: set err and go to DONE. No write, sum stays 0.
  - count == 0: go to WRITE.
  - Otherwise: go to ACCUM.
- ACCUM
  - mem_addr = BASE_ADDR+1+idx, computed modulo 2^AW (address wrap allowed).
  - Each edge: sum <= sum + mem_dout (mod 2^16); ovf |= carry-out; idx <= idx+1.
  - Leave for WRITE after the edge where idx == count-1.
- WRITE: mem_addr=RESULT_ADDR, mem_din=sum, mem_wr=1 for exactly one cycle; go to DONE.
- DONE: done=1 for one cycle; return to IDLE.
- start is ignored while busy; no queuing.
- mem_din = sum in every state, but mem_wr is high only in WRITE.
- The engine is unaware of RESULT_ADDR overlapping the element range; it reads all elements before the single write.

## Timing
- Reset (async, immediate) values: state=IDLE; mem_addr=0, mem_din=0, mem_wr=0, busy=0, done=0, sum=0, ovf=0, err=0; internal count=0, idx=0.
- start sampled at edge E0. LDCNT runs in the cycle after E0.
- ACCUM occupies N cycles, WRITE 1 cycle, DONE 1 cycle.
- done is high during cycle N+3 after E0; IDLE is re-entered at edge N+4.
- N=0 gives done in cycle 3; the err path gives done in cycle 2.
- The memory read is combinational, so mem_dout is used in the same cycle its address is driven; no read wait states.
- The memory write commits at the rising edge ending the WRITE cycle.
- rst_n asserted mid-run: outputs go to reset values immediately and mem_wr drops at once. A write whose edge has not yet occurred is lost.
- A new start on the same cycle as done is ignored. start is accepted from the first IDLE cycle.

## Test plan
- Memory preloaded with 48=0x000B and 49..59=1..11; pulse start:
  - RESULT_ADDR (60) = 0x0042; sum=0x0042; ovf=0; err=0.
  - done pulses exactly 14 cycles after the start edge.
- Count=0 at 48: no element reads; 60 = 0x0000; done in cycle 3.
- Count=2, elements 0xFFFF and 0x0002: sum=0x0001, ovf=1, 60 = 0x0001.
- Count=0x0100: err=1; no mem_wr asserted at any point; done in cycle 2.
- BASE_ADDR=254 override, count=3 at 254, elements at 255, 0, 1 = 5, 6, 7: addresses wrap to 0 and 1; sum=0x0012.
- Reset mid-run:
  - Drop rst_n during ACCUM: busy, mem_wr and sum go to 0 immediately; address 60 remains unchanged.
  - A subsequent start completes a normal run.
  - start pulses while busy have no effect on the result.
